pmp_checker_seq: RTL and testbench
==================================

# pmp_checker_seq

Sequential, parametrised Physical Memory Protection checker that sits between the core's fetch/LSU address paths and the exception logic. It accepts one access request through a valid/ready handshake. It scans the PMP entries in groups, with RISC-V lowest-index-match priority and early exit. It returns a registered permit/fault response with the matching entry index. It replaces a single-cycle combinational check with a bounded-depth scan, so PMP_ENTRIES can scale to 64 without lengthening the critical path.

## Interface
- XLEN, default `XLEN_64b: width code; address width AW = 1<<(XLEN+4).
- PMP_ENTRIES, default 16: number of implemented entries, 1..64.
- EPC (entries per cycle), default 4: entries evaluated per scan cycle. Must divide PMP_ENTRIES. G = PMP_ENTRIES/EPC groups.
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous abort of any in-flight request.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  high only in IDLE.
- i_req_addr  in  AW  byte address.
- i_req_type  in  2  00 fetch, 01 load, 10 store, 11 reserved (treated as load).
- i_req_priv  in  2  privilege of the access.
- i_concat_pmpaddr  in  AW*64  pmpaddr0..63, entry i at [i*AW +: AW].
- i_concat_pmpcfg  in  512  pmpcfg bytes, entry i at [i*8 +: 8]: R[0] W[1] X[2] A[4:3] L[7].
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumed.
- o_rsp_fault  out  1  access denied.
- o_rsp_exception_code  out  4  `E_FETCH_ACCESS_FAULT / `E_LOAD_ACCESS_FAULT / `E_STORE_ACCESS_FAULT, else `NO_E.
- o_rsp_matched  out  1  an entry matched.
- o_rsp_match_idx  out  6  index of the deciding entry; 0 when no match.

## Operation
- FSM states are IDLE, SCAN and RESP.
- IDLE:
  - Accept on i_req_valid & o_req_ready; latch addr, type and priv; group counter g = 0.
  - If priv == `MACHINE and the lock feature is compiled out, go to RESP with no fault and matched = 0.
  - Otherwise go to SCAN.
- SCAN evaluates entries g*EPC .. g*EPC+EPC-1 each cycle. The lowest-index match in the group decides, then go to RESP. With no match, g++; after group G-1, go to RESP with the no-match result.
- Entries with A=OFF (00) never match.
- Match rules:
  - TOR: lo = (j==0) ? 0 : pmpaddr[j-1]<<2, hi = pmpaddr[j]<<2; match when lo ≤ addr < hi. lo ≥ hi never matches.
  - NA4: match when base ≤ addr < base+4, with base = pmpaddr<<2.
  - NAPOT: t = trailing ones of pmpaddr, size = 2^(t+3), base = (pmpaddr<<2) & ~(size-1); match when base ≤ addr < base+size. All-ones pmpaddr matches every address.
  - All comparisons are unsigned at AW+2 bits, so no wrap-around at the top of the address space.
- Permission: fetch needs X, load needs R, store needs W.
- S/U privilege: a matched entry without the needed permission faults; no match also faults.
- Fault code follows the type: fetch → `E_FETCH_ACCESS_FAULT, load → `E_LOAD_ACCESS_FAULT, store → `E_STORE_ACCESS_FAULT.
- RESP holds all response outputs stable until i_rsp_ready, then returns to IDLE; o_rsp_valid drops the next cycle.
- i_flush has priority in every state: go to IDLE, clear o_rsp_valid, and issue no response.
- The pmpcfg/pmpaddr inputs are sampled live each SCAN cycle. The core stalls CSR writes while o_req_ready is low.

## Timing
- Reset values: state IDLE, o_req_ready 1, o_rsp_valid 0, o_rsp_fault 0, o_rsp_matched 0, o_rsp_match_idx 0, o_rsp_exception_code `NO_E.
- All response outputs are registered; o_req_ready is decoded from state.
- Let acceptance happen at clock edge T, with k groups evaluated. o_rsp_valid is high from edge T+k+1.
  - Best case is T+2; worst case is T+G+1.
  - M-mode bypass responds at T+1.
- Throughput: one request at a time; the next accept is possible at the earliest one cycle after the RESP handshake.
- Reset asserted mid-scan returns to reset values immediately (asynchronously).

## Configuration
- PMP_LOCK_EN defined: M-mode requests are scanned like any other. A matching entry with L=1 enforces its R/W/X; a match with L=0, or no match, permits.
- PMP_LOCK_EN undefined: M-mode always bypasses via the 1-cycle path, and the L bit is ignored.

## Structure
- riscv_defines.vh gains:
  - PMP A encodings: OFF, TOR, NA4, NAPOT.
  - Access-type codes.
  - `E_FETCH_ACCESS_FAULT (4'd1), alongside the existing load and store access-fault codes.
- Sub-module pmp_entry_match: a combinational single-entry matcher taking addr, prev/current pmpaddr, cfg and type, returning match and allow. It is instantiated EPC times.

## Test plan
- U-mode load to 0x800, entry0 NAPOT pmpaddr=0x1FF, cfg=0x19 (R, NAPOT) → no fault, matched=1, idx 0, valid at T+2.
- Same setup with a store to 0x800 → fault=1, code `E_STORE_ACCESS_FAULT, idx 0.
- TOR check, pmpaddr4=0x400, pmpaddr5=0x800, cfg5=0x0C (X, TOR), EPC=4:
  - U fetch 0x1FFC → permit, idx 5, valid at T+3.
  - U fetch 0x2000 → no match, code `E_FETCH_ACCESS_FAULT, valid at T+5.
- Priority: entry2 NA4 pmpaddr=0x40, cfg=0x10 (no permissions); entry3 NAPOT covering 0x100 with RWX; S load 0x100 → fault, idx 2.
- M-mode load with entry0 cfg=0x98 (L, NAPOT, no permissions), pmpaddr=0x1FF:
  - PMP_LOCK_EN undefined → permit at T+1.
  - PMP_LOCK_EN defined → load access fault, idx 0.
- Handshake and flush:
  - Hold i_rsp_ready low 3 cycles → outputs stable throughout.
  - i_flush in the first SCAN cycle → IDLE next cycle, no o_rsp_valid.

Source files
------------

// File: rtl/pmp_checker_seq_pkg.sv
// Shared constants and types for the sequential PMP checker.
// Also carries the riscv_defines additions: PMP A encodings, access types, access-fault codes.
`ifndef RISCV_DEFINES_VH
`define RISCV_DEFINES_VH
`define XLEN_32b             1
`define XLEN_64b             2
`define USER                 2'b00
`define SUPERVISOR           2'b01
`define MACHINE              2'b11
`define PMP_A_OFF            2'b00
`define PMP_A_TOR            2'b01
`define PMP_A_NA4            2'b10
`define PMP_A_NAPOT          2'b11
`define ACC_FETCH            2'b00
`define ACC_LOAD             2'b01
`define ACC_STORE            2'b10
`define NO_E                 4'd0
`define E_FETCH_ACCESS_FAULT 4'd1
`define E_LOAD_ACCESS_FAULT  4'd5
`define E_STORE_ACCESS_FAULT 4'd7
`endif

package pmp_checker_seq_pkg;

  localparam int unsigned XLEN_32B = `XLEN_32b;
  localparam int unsigned XLEN_64B = `XLEN_64b;

  localparam logic [1:0] PRIV_M = `MACHINE;

  localparam logic [1:0] PMP_A_OFF   = `PMP_A_OFF;
  localparam logic [1:0] PMP_A_TOR   = `PMP_A_TOR;
  localparam logic [1:0] PMP_A_NA4   = `PMP_A_NA4;
  localparam logic [1:0] PMP_A_NAPOT = `PMP_A_NAPOT;

  localparam logic [1:0] ACC_FETCH = `ACC_FETCH;
  localparam logic [1:0] ACC_LOAD  = `ACC_LOAD;
  localparam logic [1:0] ACC_STORE = `ACC_STORE;

  localparam logic [3:0] NO_E                 = `NO_E;
  localparam logic [3:0] E_FETCH_ACCESS_FAULT = `E_FETCH_ACCESS_FAULT;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT  = `E_LOAD_ACCESS_FAULT;
  localparam logic [3:0] E_STORE_ACCESS_FAULT = `E_STORE_ACCESS_FAULT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Reserved access type 11 behaves as a load.
  function automatic logic [3:0] fault_code(input logic [1:0] acc);
    case (acc)
      ACC_FETCH: fault_code = E_FETCH_ACCESS_FAULT;
      ACC_STORE: fault_code = E_STORE_ACCESS_FAULT;
      default:   fault_code = E_LOAD_ACCESS_FAULT;
    endcase
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational single-entry PMP matcher: address-range match plus the permission
// bit the access type needs. Comparisons are done at AW+2 bits so nothing wraps.
module pmp_entry_match
  import pmp_checker_seq_pkg::*;
#(
  parameter int unsigned AW = 64
) (
  input  logic [AW-1:0] i_addr,
  input  logic [AW-1:0] i_prev_pmpaddr,
  input  logic [AW-1:0] i_cur_pmpaddr,
  input  logic          i_first,
  input  logic [7:0]    i_cfg,
  input  logic [1:0]    i_type,
  output logic          o_match,
  output logic          o_allow
);

  logic [AW+1:0] addr_ext;
  logic [AW+1:0] cur_ext;
  logic [AW+1:0] prev_ext;
  logic [AW-1:0] cur_inc;
  logic [AW+1:0] napot_mask;
  logic          unused_cfg;

  assign addr_ext = {2'b00, i_addr};
  assign cur_ext  = {i_cur_pmpaddr, 2'b00};
  assign prev_ext = i_first ? '0 : {i_prev_pmpaddr, 2'b00};
  assign cur_inc  = i_cur_pmpaddr + AW'(1);
  // Ones at and below the lowest zero of pmpaddr span the region; all-ones pmpaddr gives mask 0.
  assign napot_mask = ~{i_cur_pmpaddr ^ cur_inc, 2'b11};

  always_comb begin
    o_match = 1'b0;
    case (i_cfg[4:3])
      PMP_A_TOR:   o_match = (addr_ext >= prev_ext) && (addr_ext < cur_ext);
      PMP_A_NA4:   o_match = ({2'b00, i_addr[AW-1:2]} == i_cur_pmpaddr);
      PMP_A_NAPOT: o_match = ((addr_ext & napot_mask) == (cur_ext & napot_mask));
      default:     o_match = 1'b0;
    endcase
  end

  always_comb begin
    o_allow = i_cfg[0];
    case (i_type)
      ACC_FETCH: o_allow = i_cfg[2];
      ACC_STORE: o_allow = i_cfg[1];
      default:   o_allow = i_cfg[0];
    endcase
  end

  assign unused_cfg = ^i_cfg[7:5];

endmodule

// File: rtl/pmp_checker_seq.sv
// Sequential PMP checker: scans EPC entries per cycle, lowest index wins, early exit.
// Build option PMP_LOCK_EN: scan M-mode requests and honour the L bit; otherwise M-mode bypasses.
//   state   | meaning
//   IDLE    | ready for a request
//   SCAN    | evaluating group g_q of EPC entries
//   RESP    | registered response held until i_rsp_ready
module pmp_checker_seq
  import pmp_checker_seq_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_64B,
  parameter int unsigned PMP_ENTRIES = 16,
  parameter int unsigned EPC         = 4,
  localparam int unsigned AW         = 1 << (XLEN + 4)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [AW-1:0]     i_req_addr,
  input  logic [1:0]        i_req_type,
  input  logic [1:0]        i_req_priv,
  input  logic [AW*64-1:0]  i_concat_pmpaddr,
  input  logic [511:0]      i_concat_pmpcfg,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_fault,
  output logic [3:0]        o_rsp_exception_code,
  output logic              o_rsp_matched,
  output logic [5:0]        o_rsp_match_idx
);

  localparam int unsigned G  = PMP_ENTRIES / EPC;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned KW = (EPC > 1) ? $clog2(EPC) : 1;

`ifdef PMP_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    type_q, type_d;
  logic [1:0]    priv_q, priv_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_fault_q, rsp_fault_d;
  logic          rsp_matched_q, rsp_matched_d;
  logic [5:0]    rsp_idx_q, rsp_idx_d;
  logic [3:0]    rsp_code_q, rsp_code_d;

  logic [AW-1:0] pmpaddr [64];
  logic [7:0]    pmpcfg  [64];
  logic [5:0]    ent_idx  [EPC];
  logic [5:0]    prev_idx [EPC];
  logic [EPC-1:0] ent_match;
  logic [EPC-1:0] ent_allow;

  logic          hit;
  logic [KW-1:0] hit_k;
  logic [5:0]    hit_idx;
  logic          hit_allow;
  logic          hit_lock;
  logic          is_m;
  logic          scan_fault;
  logic          last_group;
  logic          unused_lock;

  for (genvar e = 0; e < 64; e++) begin : g_unpack
    assign pmpaddr[e] = i_concat_pmpaddr[e*AW +: AW];
    assign pmpcfg[e]  = i_concat_pmpcfg[e*8 +: 8];
  end

  for (genvar k = 0; k < EPC; k++) begin : g_ent
    assign ent_idx[k]  = 6'(int'(g_q) * int'(EPC) + k);
    assign prev_idx[k] = (ent_idx[k] == 6'd0) ? 6'd0 : ent_idx[k] - 6'd1;

    pmp_entry_match #(.AW(AW)) u_match (
      .i_addr         (addr_q),
      .i_prev_pmpaddr (pmpaddr[prev_idx[k]]),
      .i_cur_pmpaddr  (pmpaddr[ent_idx[k]]),
      .i_first        (ent_idx[k] == 6'd0),
      .i_cfg          (pmpcfg[ent_idx[k]]),
      .i_type         (type_q),
      .o_match        (ent_match[k]),
      .o_allow        (ent_allow[k])
    );
  end

  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    for (int k = EPC - 1; k >= 0; k--) begin
      if (ent_match[k]) begin
        hit   = 1'b1;
        hit_k = KW'(k);
      end
    end
  end

  assign hit_idx    = ent_idx[hit_k];
  assign hit_allow  = ent_allow[hit_k];
  assign hit_lock   = pmpcfg[hit_idx][7];
  assign is_m       = (priv_q == PRIV_M);
  assign last_group = (g_q == GW'(G - 1));

  // M-mode only gets here with locking built in: unlocked or unmatched entries permit.
  always_comb begin
    if (hit) begin
      scan_fault = is_m ? (LOCK_EN && hit_lock && !hit_allow) : !hit_allow;
    end else begin
      scan_fault = !is_m;
    end
  end

  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    addr_d        = addr_q;
    type_d        = type_q;
    priv_d        = priv_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_fault_d   = rsp_fault_q;
    rsp_matched_d = rsp_matched_q;
    rsp_idx_d     = rsp_idx_q;
    rsp_code_d    = rsp_code_q;
    if (i_flush) begin
      state_d     = ST_IDLE;
      rsp_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req_valid) begin
            addr_d = i_req_addr;
            type_d = i_req_type;
            priv_d = i_req_priv;
            g_d    = '0;
            if (!LOCK_EN && (i_req_priv == PRIV_M)) begin
              state_d       = ST_RESP;
              rsp_valid_d   = 1'b1;
              rsp_fault_d   = 1'b0;
              rsp_matched_d = 1'b0;
              rsp_idx_d     = 6'd0;
              rsp_code_d    = NO_E;
            end else begin
              state_d = ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (hit || last_group) begin
            state_d       = ST_RESP;
            rsp_valid_d   = 1'b1;
            rsp_fault_d   = scan_fault;
            rsp_matched_d = hit;
            rsp_idx_d     = hit ? hit_idx : 6'd0;
            rsp_code_d    = scan_fault ? fault_code(type_q) : NO_E;
          end else begin
            g_d = g_q + GW'(1);
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      g_q           <= '0;
      addr_q        <= '0;
      type_q        <= '0;
      priv_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_fault_q   <= 1'b0;
      rsp_matched_q <= 1'b0;
      rsp_idx_q     <= 6'd0;
      rsp_code_q    <= NO_E;
    end else begin
      state_q       <= state_d;
      g_q           <= g_d;
      addr_q        <= addr_d;
      type_q        <= type_d;
      priv_q        <= priv_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_fault_q   <= rsp_fault_d;
      rsp_matched_q <= rsp_matched_d;
      rsp_idx_q     <= rsp_idx_d;
      rsp_code_q    <= rsp_code_d;
    end
  end

  assign o_req_ready          = (state_q == ST_IDLE);
  assign o_rsp_valid          = rsp_valid_q;
  assign o_rsp_fault          = rsp_fault_q;
  assign o_rsp_matched        = rsp_matched_q;
  assign o_rsp_match_idx      = rsp_idx_q;
  assign o_rsp_exception_code = rsp_code_q;

  assign unused_lock = hit_lock;

endmodule

// File: tb/tb_pmp_checker_seq.sv
// Directed bench for pmp_checker_seq (default build: 64-bit, 16 entries, 4 per cycle, no lock).
module tb_pmp_checker_seq;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [63:0]   req_addr = '0;
  logic [1:0]    req_type = '0;
  logic [1:0]    req_priv = '0;
  logic [4095:0] pmpaddr_bus = '0;
  logic [511:0]  pmpcfg_bus = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_fault;
  logic [3:0]    rsp_code;
  logic          rsp_matched;
  logic [5:0]    rsp_idx;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [1:0] T_FETCH = 2'b00, T_LOAD = 2'b01, T_STORE = 2'b10;
  localparam logic [1:0] P_U = 2'b00, P_S = 2'b01, P_M = 2'b11;
  localparam logic [3:0] C_NONE = 4'd0, C_FETCH = 4'd1, C_LOAD = 4'd5, C_STORE = 4'd7;

  always #5 clk = ~clk;

  pmp_checker_seq dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_flush              (flush),
    .i_req_valid          (req_valid),
    .o_req_ready          (req_ready),
    .i_req_addr           (req_addr),
    .i_req_type           (req_type),
    .i_req_priv           (req_priv),
    .i_concat_pmpaddr     (pmpaddr_bus),
    .i_concat_pmpcfg      (pmpcfg_bus),
    .o_rsp_valid          (rsp_valid),
    .i_rsp_ready          (rsp_ready),
    .o_rsp_fault          (rsp_fault),
    .o_rsp_exception_code (rsp_code),
    .o_rsp_matched        (rsp_matched),
    .o_rsp_match_idx      (rsp_idx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic [63:0] a, input logic [7:0] c);
    pmpaddr_bus[i*64 +: 64] = a;
    pmpcfg_bus[i*8 +: 8]    = c;
  endtask

  task automatic clear_entries();
    pmpaddr_bus = '0;
    pmpcfg_bus  = '0;
  endtask

  task automatic run(input string tag, input logic [63:0] addr, input logic [1:0] typ,
                     input logic [1:0] priv, input logic exp_fault, input logic exp_match,
                     input logic [5:0] exp_idx, input logic [3:0] exp_code,
                     input int exp_lat, input int hold);
    int c;
    @(negedge clk);
    chk({tag, ".ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_type  = typ;
    req_priv  = priv;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    c = 0;
    while (!rsp_valid && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk({tag, ".latency"}, 64'(c + 1), 64'(exp_lat));
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(posedge clk);
        #1;
      end
      chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, ".fault"}, 64'(rsp_fault), 64'(exp_fault));
      chk({tag, ".matched"}, 64'(rsp_matched), 64'(exp_match));
      chk({tag, ".idx"}, 64'(rsp_idx), 64'(exp_idx));
      chk({tag, ".code"}, 64'(rsp_code), 64'(exp_code));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, ".valid_drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 64'(req_ready), 64'd1);
    chk("rst.valid", 64'(rsp_valid), 64'd0);
    chk("rst.fault", 64'(rsp_fault), 64'd0);
    chk("rst.matched", 64'(rsp_matched), 64'd0);
    chk("rst.idx", 64'(rsp_idx), 64'd0);
    chk("rst.code", 64'(rsp_code), 64'(C_NONE));
    @(negedge clk);
    rst_n = 1'b1;

    // entry0 NAPOT 0x1FF covers 0x0..0xFFF, read only
    clear_entries();
    set_entry(0, 64'h1FF, 8'h19);
    run("napot_load",  64'h800, T_LOAD,  P_U, 1'b0, 1'b1, 6'd0, C_NONE,  2, 0);
    run("napot_store", 64'h800, T_STORE, P_U, 1'b1, 1'b1, 6'd0, C_STORE, 2, 3);
    run("napot_miss",  64'h1000, T_LOAD, P_U, 1'b1, 1'b0, 6'd0, C_LOAD,  5, 0);

    // TOR entry5 over [0x1000, 0x2000), execute only
    clear_entries();
    set_entry(4, 64'h400, 8'h00);
    set_entry(5, 64'h800, 8'h0C);
    run("tor_in",   64'h1FFC, T_FETCH, P_U, 1'b0, 1'b1, 6'd5, C_NONE,  3, 0);
    run("tor_lo",   64'h1000, T_FETCH, P_S, 1'b0, 1'b1, 6'd5, C_NONE,  3, 0);
    run("tor_hi",   64'h2000, T_FETCH, P_U, 1'b1, 1'b0, 6'd0, C_FETCH, 5, 0);
    run("tor_load", 64'h1800, T_LOAD,  P_U, 1'b1, 1'b1, 6'd5, C_LOAD,  3, 0);

    // entry2 NA4 at 0x100 with no permissions shadows entry3 NAPOT 0x0..0x3FF RWX
    clear_entries();
    set_entry(2, 64'h40, 8'h10);
    set_entry(3, 64'h7F, 8'h1F);
    run("prio_na4",   64'h100, T_LOAD,  P_S, 1'b1, 1'b1, 6'd2, C_LOAD, 2, 0);
    run("prio_napot", 64'h104, T_STORE, P_S, 1'b0, 1'b1, 6'd3, C_NONE, 2, 0);

    // all-ones NAPOT matches the top of the address space
    clear_entries();
    set_entry(9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h1B);
    run("napot_all", 64'hFFFF_FFFF_FFFF_FFF0, T_STORE, P_U, 1'b0, 1'b1, 6'd9, C_NONE, 4, 0);

    // M-mode bypasses even a locked no-permission entry
    clear_entries();
    set_entry(0, 64'h1FF, 8'h98);
    run("m_bypass", 64'h800, T_LOAD, P_M, 1'b0, 1'b0, 6'd0, C_NONE, 2 - 1, 1);

    // flush in the first SCAN cycle suppresses a group-0 hit
    clear_entries();
    set_entry(0, 64'h1FF, 8'h19);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 64'h800;
    req_type  = T_LOAD;
    req_priv  = P_U;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush.ready", 64'(req_ready), 64'd1);
    chk("flush.valid", 64'(rsp_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush.valid_late", 64'(rsp_valid), 64'd0);
    run("after_flush", 64'h800, T_LOAD, P_U, 1'b0, 1'b1, 6'd0, C_NONE, 2, 0);

    // async reset mid-scan
    clear_entries();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 64'h5000;
    req_type  = T_LOAD;
    req_priv  = P_U;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("arst.busy", 64'(req_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.ready", 64'(req_ready), 64'd1);
    chk("arst.valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_arst", 64'h5000, T_LOAD, P_U, 1'b1, 1'b0, 6'd0, C_LOAD, 5, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
